// File: rtl/demux32_fifo_pkg.sv
// Shared types and constants for the 1-to-4 word distributor.
//   WORD_W  : data word width
//   N_LANES : number of output lanes
//   SEL_W   : width of the lane select
package demux32_fifo_pkg;

  localparam int WORD_W  = 32;
  localparam int N_LANES = 4;
  localparam int SEL_W   = 2;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [SEL_W-1:0]  lane_sel_t;

  // One-hot lane mask for a lane select.
  function automatic logic [N_LANES-1:0] lane_onehot(input lane_sel_t sel);
    return {{(N_LANES-1){1'b0}}, 1'b1} << sel;
  endfunction

endpackage

// File: rtl/demux32_fifo_if.sv
// Bus bundle between the distributor, its producer and its four consumers.
//   in_valid/in_ready/in_data/in_sel : producer stream with lane select
//   out_valid/out_ready              : per-lane drain handshake (bit i = lane i)
//   out_data0..3                     : head word of each lane
//   lane_full                        : per-lane full flag
//   drop_err                         : sticky producer-protocol violation
// master = producer/consumer side, slave = distributor.
interface demux32_fifo_if;
  import demux32_fifo_pkg::*;

  logic               in_valid;
  logic               in_ready;
  word_t              in_data;
  lane_sel_t          in_sel;
  logic [N_LANES-1:0] out_valid;
  logic [N_LANES-1:0] out_ready;
  word_t              out_data0;
  word_t              out_data1;
  word_t              out_data2;
  word_t              out_data3;
  logic [N_LANES-1:0] lane_full;
  logic               drop_err;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
           lane_full, drop_err
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
           lane_full, drop_err
  );

endinterface

// File: rtl/demux32_lane_fifo.sv
// Single-lane FIFO of DEPTH words with a registered head output.
//   push/din  : write a word (ignored when full)
//   pop       : advance head (ignored when empty)
//   dout      : registered head word; holds last value when empty, 0 after reset
//   valid     : lane holds at least one word
//   full      : lane holds DEPTH words
module demux32_lane_fifo
  import demux32_fifo_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  word_t din,
  input  logic  pop,
  output word_t dout,
  output logic  valid,
  output logic  full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  word_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_nx, rd_ptr_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  word_t            dout_q, head_nx;
  logic             push_ok, pop_ok;

  assign valid   = (cnt_q != '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & valid;
  assign dout    = dout_q;

  // The head is registered so an empty lane shows a defined value instead of
  // uninitialised storage. When the next head slot is the one being written
  // this cycle, take it from din rather than from the array.
  always_comb begin
    wr_ptr_nx = wr_ptr_q;
    rd_ptr_nx = rd_ptr_q;
    head_nx   = dout_q;
    if (push_ok) wr_ptr_nx = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_nx = rd_ptr_q + PTR_W'(1);
    cnt_nx = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    if (cnt_nx != '0) begin
      head_nx = (push_ok && (rd_ptr_nx == wr_ptr_q)) ? din : mem[rd_ptr_nx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_nx;
      rd_ptr_q <= rd_ptr_nx;
      cnt_q    <= cnt_nx;
      dout_q   <= head_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/demux32_fifo.sv
// Registered 1-to-4 word distributor: steers a producer stream into one of
// four per-lane FIFOs, each drained by its own valid/ready port.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : distributor side of demux32_fifo_if (see interface header)
module demux32_fifo
  import demux32_fifo_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic            clk,
  input logic            rst_n,
  demux32_fifo_if.slave  bus
);

  word_t              lane_dout [N_LANES];
  logic [N_LANES-1:0] lane_push, lane_pop, lane_valid, lane_full_w;
  logic               in_ready;
  logic               stall_q, drop_err_q, viol;
  lane_sel_t          sel_q;
  word_t              data_q;

  // Ready depends only on registered fullness; a pop on a full lane frees
  // space for the following cycle, never the current one.
  assign in_ready  = ~lane_full_w[bus.in_sel];
  assign lane_push = (bus.in_valid && in_ready) ? lane_onehot(bus.in_sel) : '0;
  assign lane_pop  = bus.out_ready & lane_valid;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    demux32_lane_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (lane_push[i]),
      .din   (bus.in_data),
      .pop   (lane_pop[i]),
      .dout  (lane_dout[i]),
      .valid (lane_valid[i]),
      .full  (lane_full_w[i])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = lane_valid;
  assign bus.lane_full = lane_full_w;
  assign bus.out_data0 = lane_dout[0];
  assign bus.out_data1 = lane_dout[1];
  assign bus.out_data2 = lane_dout[2];
  assign bus.out_data3 = lane_dout[3];
  assign bus.drop_err  = drop_err_q;

  // A stalled offer must be repeated unchanged until taken.
  assign viol = stall_q && (!bus.in_valid || (bus.in_sel != sel_q) ||
                            (bus.in_data != data_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q    <= 1'b0;
      sel_q      <= '0;
      data_q     <= '0;
      drop_err_q <= 1'b0;
    end else begin
      stall_q <= bus.in_valid & ~in_ready;
      sel_q   <= bus.in_sel;
      data_q  <= bus.in_data;
      if (viol) drop_err_q <= 1'b1;
    end
  end

endmodule
